// File: rtl/shiftreg_cfg_rx.sv
// shiftreg_cfg_rx: chip-side receiver for the configuration shift-register link.
// Serial bits are deserialised into a static and a dynamic shadow register.
// A commit strobe copies each shadow that holds exactly one frame to its output
// register. Select conflicts and wrong-length commits raise sticky error flags.
module shiftreg_cfg_rx #(
  parameter int SIZESRSTAT  = 88,
  parameter int SIZESRDYN   = 16,
  parameter int SIZEADDRMUX = 7
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   sdi,
  input  logic                   sel_stat,
  input  logic                   sel_dyn,
  input  logic                   en_fin,
  input  logic                   err_clr,
  output logic [SIZESRSTAT-1:0]  stat_cfg,
  output logic [SIZESRDYN-1:0]   dyn_cfg,
  output logic [SIZEADDRMUX-1:0] mux_addr,
  output logic                   stat_upd,
  output logic                   dyn_upd,
  output logic                   sdo,
  output logic                   err_sel,
  output logic                   err_len
);

  // Counter widths leave room for the saturated "overlength" code SIZE+1.
  localparam int CW_S = $clog2(SIZESRSTAT + 2);
  localparam int CW_D = $clog2(SIZESRDYN + 2);

  localparam logic [CW_S-1:0] STAT_FULL = CW_S'(SIZESRSTAT);
  localparam logic [CW_S-1:0] STAT_OVR  = CW_S'(SIZESRSTAT + 1);
  localparam logic [CW_D-1:0] DYN_FULL  = CW_D'(SIZESRDYN);
  localparam logic [CW_D-1:0] DYN_OVR   = CW_D'(SIZESRDYN + 1);

  // Saturating bit counters: once past SIZE they stick at SIZE+1 so that an
  // overlength frame can never wrap back to a value that looks complete.
  function automatic logic [CW_S-1:0] sat_inc_stat(input logic [CW_S-1:0] c);
    sat_inc_stat = (c == STAT_OVR) ? c : c + CW_S'(1);
  endfunction

  function automatic logic [CW_D-1:0] sat_inc_dyn(input logic [CW_D-1:0] c);
    sat_inc_dyn = (c == DYN_OVR) ? c : c + CW_D'(1);
  endfunction

  logic [SIZESRSTAT-1:0] r_stat_sh;
  logic [SIZESRDYN-1:0]  r_dyn_sh;
  logic [CW_S-1:0]       r_stat_cnt;
  logic [CW_D-1:0]       r_dyn_cnt;
  logic [SIZESRSTAT-1:0] r_stat_cfg;
  logic [SIZESRDYN-1:0]  r_dyn_cfg;
  logic                  r_stat_upd;
  logic                  r_dyn_upd;
  logic                  r_err_sel;
  logic                  r_err_len;

  logic w_conflict;
  logic w_shift_stat;
  logic w_shift_dyn;
  logic w_stat_full;
  logic w_stat_empty;
  logic w_dyn_full;
  logic w_dyn_empty;
  logic w_set_sel;
  logic w_set_len;
  logic w_sdo;

  assign w_conflict   = sel_stat & sel_dyn;
  assign w_shift_stat = sel_stat & ~sel_dyn & ~en_fin;
  assign w_shift_dyn  = sel_dyn & ~sel_stat & ~en_fin;
  assign w_stat_full  = (r_stat_cnt == STAT_FULL);
  assign w_stat_empty = (r_stat_cnt == '0);
  assign w_dyn_full   = (r_dyn_cnt == DYN_FULL);
  assign w_dyn_empty  = (r_dyn_cnt == '0);

  // A commit outranks a select conflict, so the conflict flag is only raised
  // on edges that are not commit edges.
  assign w_set_sel = w_conflict & ~en_fin;
  assign w_set_len = en_fin & ((~w_stat_full & ~w_stat_empty) |
                               (~w_dyn_full & ~w_dyn_empty));

  // Static shadow and counter: shift on a clean static select, clear count on commit.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_stat_sh  <= '0;
      r_stat_cnt <= '0;
    end else if (en_fin) begin
      r_stat_cnt <= '0;
    end else if (w_shift_stat) begin
      r_stat_sh  <= {r_stat_sh[SIZESRSTAT-2:0], sdi};
      r_stat_cnt <= sat_inc_stat(r_stat_cnt);
    end
  end

  // Dynamic shadow and counter: same scheme on the dynamic select.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_dyn_sh  <= '0;
      r_dyn_cnt <= '0;
    end else if (en_fin) begin
      r_dyn_cnt <= '0;
    end else if (w_shift_dyn) begin
      r_dyn_sh  <= {r_dyn_sh[SIZESRDYN-2:0], sdi};
      r_dyn_cnt <= sat_inc_dyn(r_dyn_cnt);
    end
  end

  // Output registers: each commits independently only when its frame is complete.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_stat_cfg <= '0;
      r_dyn_cfg  <= '0;
      r_stat_upd <= 1'b0;
      r_dyn_upd  <= 1'b0;
    end else begin
      r_stat_upd <= en_fin & w_stat_full;
      r_dyn_upd  <= en_fin & w_dyn_full;
      if (en_fin && w_stat_full) begin
        r_stat_cfg <= r_stat_sh;
      end
      if (en_fin && w_dyn_full) begin
        r_dyn_cfg <= r_dyn_sh;
      end
    end
  end

  // Sticky error flags: a new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_err_sel <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      r_err_sel <= w_set_sel | (r_err_sel & ~err_clr);
      r_err_len <= w_set_len | (r_err_len & ~err_clr);
    end
  end

  // Daisy-chain output: MSB of whichever shadow is selected alone, else 0.
  always_comb begin
    w_sdo = 1'b0;
    if (sel_stat && !sel_dyn) begin
      w_sdo = r_stat_sh[SIZESRSTAT-1];
    end else if (sel_dyn && !sel_stat) begin
      w_sdo = r_dyn_sh[SIZESRDYN-1];
    end
  end

  assign sdo      = w_sdo;
  assign stat_cfg = r_stat_cfg;
  assign dyn_cfg  = r_dyn_cfg;
  assign mux_addr = r_dyn_cfg[SIZEADDRMUX-1:0];
  assign stat_upd = r_stat_upd;
  assign dyn_upd  = r_dyn_upd;
  assign err_sel  = r_err_sel;
  assign err_len  = r_err_len;

endmodule

// File: doc/shiftreg_cfg_rx.md
Name: shiftreg_cfg_rx

Overview:
Receiving end of the configuration shift-register protocol driven by the `fsm` controller (`sel_stat`, `sel_dyn`, `en_fin`).
- Deserialises a serial bit stream into a static shadow register and a dynamic shadow register.
- On the `en_fin` strobe, commits each shadow that holds a complete frame to its output register.
- Flags framing errors.
- Sits on the chip side, between the serial configuration link and the analog/mux configuration bits.

Parameters:
- SIZESRSTAT, 88, static shift-register length in bits
- SIZESRDYN, 16, dynamic shift-register length in bits
- SIZEADDRMUX, 7, width of mux address field taken from the committed dynamic word (must be <= SIZESRDYN)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- sdi  in  1  serial data in, MSB of frame first
- sel_stat  in  1  shift-enable for static register
- sel_dyn  in  1  shift-enable for dynamic register
- en_fin  in  1  commit strobe, one-cycle pulse expected
- err_clr  in  1  clears sticky error flags
- stat_cfg  out  SIZESRSTAT  committed static configuration
- dyn_cfg  out  SIZESRDYN  committed dynamic configuration
- mux_addr  out  SIZEADDRMUX  = dyn_cfg[SIZEADDRMUX-1:0]
- stat_upd  out  1  one-cycle pulse, stat_cfg updated
- dyn_upd  out  1  one-cycle pulse, dyn_cfg updated
- sdo  out  1  daisy-chain out: MSB of the shadow selected this cycle, else 0
- err_sel  out  1  sticky: sel_stat and sel_dyn high together
- err_len  out  1  sticky: commit attempted with wrong bit count

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - all shadows, outputs, counters and flags go to 0.
  - Reset has priority over every other input, including mid-frame; a partial frame is discarded.
- Shift:
  - Condition: sel_stat=1, sel_dyn=0, en_fin=0.
  - Action: stat_sh <= {stat_sh[SIZESRSTAT-2:0], sdi}; stat_cnt increments.
  - sel_dyn path is identical on dyn_sh / dyn_cnt.
- Counters:
  - Width $clog2(SIZE+2).
  - Each counter saturates at SIZE+1, which encodes "overlength".
  - Shifting continues past saturation; the shadow keeps the last SIZE bits.
- sdo: combinational from shadow MSB.
  - sel_stat=1 and sel_dyn=0 -> stat_sh[SIZESRSTAT-1]
  - sel_dyn=1 and sel_stat=0 -> dyn_sh[SIZESRDYN-1]
  - otherwise 0
- Both selects high:
  - no shift, counters hold, sdo=0.
  - err_sel <= 1 on that edge.
- Commit (en_fin=1 at a CLK edge):
  - en_fin has priority over shifting; sdi is ignored that cycle regardless of the selects.
  - Per register, evaluated independently:
    - cnt==SIZE -> cfg <= shadow; upd=1 on the next cycle only.
    - cnt==0 -> no action, no error.
    - any other count -> cfg holds, err_len <= 1.
  - Both counters are cleared on every commit edge. Shadow contents are left as-is; they are overwritten by the next frame.
- Latency:
  - stat_cfg/dyn_cfg change on the edge that samples en_fin.
  - stat_upd/dyn_upd are high in the cycle that follows that edge, for exactly 1 cycle.
- Back-to-back en_fin:
  - The second strobe sees cnt==0 -> no action.
  - upd pulses do not repeat.
- Sticky errors:
  - err_sel and err_len hold until reset or err_clr=1.
  - If err_clr and a new error occur on the same edge, the error wins (flag stays 1).
- sel deassert mid-frame:
  - Counters and shadows hold; the frame resumes when sel returns.
  - Only en_fin or reset clears the frame.
- No other state machine: control is the counters plus the priority order reset > en_fin > sel-conflict > shift.

Test Plan:
- Reset then 88 cycles of sel_stat=1 with sdi pattern 0xA5 repeating MSB-first, then en_fin pulse -> stat_cfg equals pattern, stat_upd high exactly 1 cycle, dyn_cfg=0, err_len=0.
- 16 cycles of sel_dyn=1 shifting 0x1234, then en_fin -> dyn_cfg=16'h1234, mux_addr=7'h34, dyn_upd pulse, sdo during shift mirrors dyn_sh MSB.
- 15 dyn bits then en_fin -> dyn_cfg unchanged, err_len=1, counter=0; err_clr -> err_len=0.
- 17 dyn bits (overlength) then en_fin -> reject, err_len=1. Next clean 16-bit frame plus en_fin -> commits normally.
- sel_stat=sel_dyn=1 for 3 cycles inside a static frame -> err_sel=1, stat_cnt unchanged. Complete the remaining bits -> commit succeeds.
- RST_N=0 after 40 static bits, release, send full 88-bit frame plus en_fin -> commits new frame only, no error.
